// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory loader: geometry defaults, loader state
// encoding and the start-request legality test.
package mem_loader_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;
    localparam int COUNT_W    = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

    // A start is legal when the byte address is word-aligned and the word
    // count fits inside the data memory.
    function automatic logic start_ok(input logic [31:0]        base,
                                      input logic [COUNT_W-1:0] count,
                                      input int                 depth);
        return (base[1:0] == 2'b00) && (int'(count) <= depth);
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Loader bus: load request, upstream byte stream, data-memory write port and
// status outputs. The slave side is the loader, the master side its environment.
interface mem_loader_if
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic               start;
    logic [31:0]        base_addr;
    logic [COUNT_W-1:0] word_count;
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_ready;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [31:0]        mem_wdata;
    logic               mem_stall;
    logic               core_hold;
    logic               busy;
    logic               done;
    logic               err;

    modport slave (
        input  start, base_addr, word_count, byte_valid, byte_data, mem_stall,
        output byte_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, err
    );

    modport master (
        output start, base_addr, word_count, byte_valid, byte_data, mem_stall,
        input  byte_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, err
    );

endinterface

// File: rtl/mem_loader_byte_packer.sv
// Byte packer: collects four little-endian stream bytes into one 32-bit word.
// The assembled word is only published when the fourth byte arrives, so the
// write data stays stable between words.
module mem_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_fire,
    input  logic [7:0]  byte_data,
    output logic        word_done,
    output logic [31:0] wdata
);

    logic [1:0]  lane_reg;
    logic [31:0] wdata_reg;

    assign word_done = byte_fire && (lane_reg == 2'd3);
    assign wdata     = wdata_reg;

    // Holding registers for lanes 0..2; lane 3 goes straight into the word.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_byte_reg;

            // Capture the byte when the lane counter points at this lane.
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_byte_reg <= '0;
                end else if (byte_fire && (lane_reg == 2'(gi))) begin
                    lane_byte_reg <= byte_data;
                end
            end
        end
    endgenerate

    // Lane counter and published word; a clear restarts the word at lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_reg  <= 2'd0;
            wdata_reg <= '0;
        end else if (clear) begin
            lane_reg <= 2'd0;
        end else if (byte_fire) begin
            lane_reg <= lane_reg + 2'd1;
            if (lane_reg == 2'd3) begin
                wdata_reg <= {byte_data,
                              g_lane[2].lane_byte_reg,
                              g_lane[1].lane_byte_reg,
                              g_lane[0].lane_byte_reg};
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Memory loader: streams bytes from upstream into consecutive words of the
// data memory while holding the core in reset, then pulses done.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input logic          clk,
    input logic          rst,
    mem_loader_if.slave  bus
);

    loader_state_t      state_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [COUNT_W-1:0] remaining_reg;
    logic               byte_ready_reg;
    logic               mem_we_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               err_reg;

    logic               start_legal;
    logic               pack_clear;
    logic               byte_fire;
    logic               word_done;
    logic [31:0]        pack_wdata;
    logic               unused_base_bits;

    assign start_legal      = start_ok(bus.base_addr, bus.word_count, DEPTH);
    assign pack_clear       = (state_reg == ST_IDLE) && bus.start;
    assign byte_fire        = bus.byte_valid && byte_ready_reg;
    assign unused_base_bits = ^bus.base_addr[31:ADDR_W+2];

    mem_loader_byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (pack_clear),
        .byte_fire (byte_fire),
        .byte_data (bus.byte_data),
        .word_done (word_done),
        .wdata     (pack_wdata)
    );

    // Load sequencer with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            remaining_reg  <= '0;
            byte_ready_reg <= 1'b0;
            mem_we_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (start_legal) begin
                            addr_reg      <= bus.base_addr[ADDR_W+1:2];
                            remaining_reg <= bus.word_count;
                            busy_reg      <= 1'b1;
                            if (bus.word_count != '0) begin
                                state_reg      <= ST_RECV;
                                byte_ready_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                            end
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (word_done) begin
                        state_reg      <= ST_WRITE;
                        byte_ready_reg <= 1'b0;
                        mem_we_reg     <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (!bus.mem_stall) begin
                        mem_we_reg    <= 1'b0;
                        addr_reg      <= addr_reg + ADDR_W'(1);
                        remaining_reg <= remaining_reg - COUNT_W'(1);
                        if (remaining_reg == COUNT_W'(1)) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg      <= ST_RECV;
                            byte_ready_reg <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = addr_reg;
    assign bus.mem_wdata  = pack_wdata;
    assign bus.core_hold  = busy_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.err        = err_reg;

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: randomized byte streams and stalls
// compared against a word-list model of the expected memory writes.
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int AW  = 12;
    localparam int DEP = 4096;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_loader_if #(.ADDR_W(AW)) bus ();

    mem_loader #(.ADDR_W(AW), .DEPTH(DEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] words_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One load: model = list of (word index, word) built from the byte stream.
    // vmode: 0 always valid, 1 valid 1-of-3, 2 random. smode: 0 none, 1 three
    // stalls on the first write, 2 random stall.
    task automatic run_load(input logic [31:0] base, input int count,
                            input int vmode, input int smode);
        logic [7:0]  stream[$];
        logic [63:0] exp_q[$];
        logic [63:0] wr_q[$];
        logic [31:0] w;
        logic [31:0] a;
        logic [AW-1:0] prev_addr;
        logic [31:0] prev_data;
        int idx = 0;
        int cyc;
        int done_cycle = -1;
        int stall_cnt = 0;
        int we_cnt = 0;
        int limit;
        bit hold_bad = 0;
        bit err_seen = 0;
        bit prev_stalled = 0;
        bit v;
        bit s;

        for (int k = 0; k < count; k++) begin
            w = (k < words_q.size()) ? words_q[k] : $urandom;
            stream.push_back(w[7:0]);
            stream.push_back(w[15:8]);
            stream.push_back(w[23:16]);
            stream.push_back(w[31:24]);
            a = ((base >> 2) + 32'(k)) % 32'(DEP);
            exp_q.push_back({a, w});
        end
        limit = 20 * count + 200;

        @(negedge clk);
        bus.base_addr  = base;
        bus.word_count = 13'(count);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < limit) begin
            if (bus.err) err_seen = 1;
            if (bus.done) begin
                done_cycle = cyc;
                break;
            end
            if (!bus.core_hold || !bus.busy) hold_bad = 1;
            if (prev_stalled) begin
                check("stall_hold_we", {63'd0, bus.mem_we}, 64'd1);
                check("stall_hold_addr", 64'(bus.mem_addr), 64'(prev_addr));
                check("stall_hold_data", 64'(bus.mem_wdata), 64'(prev_data));
            end
            // A start while busy must be ignored, even an illegal one.
            bus.start = (cyc == 3);
            if (cyc == 3) begin
                bus.base_addr  = 32'h2002;
                bus.word_count = 13'd4097;
            end
            case (vmode)
                0:       v = 1;
                1:       v = (cyc % 3 == 0);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            if (v && idx < stream.size()) begin
                bus.byte_valid = 1'b1;
                bus.byte_data  = stream[idx];
                if (bus.byte_ready) idx++;
            end else begin
                bus.byte_valid = 1'b0;
                bus.byte_data  = 8'($urandom);
            end
            case (smode)
                0:       s = 0;
                1:       s = bus.mem_we && (stall_cnt < 3);
                default: s = ($urandom_range(0, 2) == 0);
            endcase
            bus.mem_stall = s;
            prev_stalled = 0;
            if (bus.mem_we) begin
                we_cnt++;
                if (s) begin
                    stall_cnt++;
                    prev_stalled = 1;
                    prev_addr = bus.mem_addr;
                    prev_data = bus.mem_wdata;
                end else begin
                    wr_q.push_back({32'(bus.mem_addr), bus.mem_wdata});
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        bus.byte_valid = 1'b0;
        bus.mem_stall = 1'b0;

        check("done_seen", {63'd0, done_cycle < 0}, 64'd0);
        if (vmode == 0) check("done_cycle", 64'(done_cycle), 64'(5 * count + 1 + stall_cnt));
        check("write_count", 64'(wr_q.size()), 64'(count));
        check("we_cycles", 64'(we_cnt), 64'(count + stall_cnt));
        check("bytes_used", 64'(idx), 64'(4 * count));
        check("core_hold_load", {63'd0, hold_bad}, 64'd0);
        check("no_err_busy", {63'd0, err_seen}, 64'd0);
        check("done_outputs", {60'd0, bus.mem_we, bus.byte_ready, bus.busy, bus.core_hold}, 64'b0011);
        for (int i = 0; i < count; i++) begin
            check("write", (i < wr_q.size()) ? wr_q[i] : 64'hFFFF_FFFF_FFFF_FFFF, exp_q[i]);
        end
        @(negedge clk);
        check("idle_after", {61'd0, bus.busy, bus.core_hold, bus.done}, 64'd0);
        if (count > 0) check("wdata_hold", 64'(bus.mem_wdata), {32'd0, exp_q[count-1][31:0]});
        $display("load base=0x%08h count=%0d vmode=%0d smode=%0d writes=%0d done_cycle=%0d stalls=%0d",
                 base, count, vmode, smode, wr_q.size(), done_cycle, stall_cnt);
        words_q.delete();
    endtask

    // Rejected start: err pulses once, loader stays idle, nothing is written.
    task automatic run_reject(input logic [31:0] base, input int count);
        int bad = 0;
        @(negedge clk);
        bus.base_addr  = base;
        bus.word_count = 13'(count);
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("err_pulse", {63'd0, bus.err}, 64'd1);
        check("reject_idle", {61'd0, bus.busy, bus.core_hold, bus.mem_we}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            if (bus.mem_we || bus.busy || bus.err || bus.done) bad++;
        end
        check("reject_quiet", 64'(bad), 64'd0);
        $display("reject base=0x%08h count=%0d bad_cycles=%0d", base, count, bad);
    endtask

    // Reset two bytes into a load: no write, no done, then a clean reload.
    task automatic run_reset_midload();
        int bad = 0;
        @(negedge clk);
        bus.base_addr  = 32'h100;
        bus.word_count = 13'd2;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outs", {58'd0, bus.byte_ready, bus.mem_we, bus.core_hold,
                              bus.busy, bus.done, bus.err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_we || bus.done || bus.busy) bad++;
        end
        check("midrst_quiet", 64'(bad), 64'd0);
        $display("reset mid-load bad_cycles=%0d", bad);
        words_q = '{32'hCAFE_F00D, 32'h0123_4567};
        run_load(32'h100, 2, 0, 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        bus.mem_stall  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {58'd0, bus.byte_ready, bus.mem_we, bus.core_hold,
                             bus.busy, bus.done, bus.err}, 64'd0);
        check("reset_addr", 64'(bus.mem_addr), 64'd0);
        check("reset_wdata", 64'(bus.mem_wdata), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_outs", {58'd0, bus.byte_ready, bus.mem_we, bus.core_hold,
                                  bus.busy, bus.done, bus.err}, 64'd0);

        words_q = '{32'h0000_0013, 32'h0010_0093};
        run_load(32'h0, 2, 0, 0);
        run_load(32'h2000, 1, 0, 1);
        run_load(32'h3FFC, 2, 0, 0);
        run_reject(32'h2002, 1);
        run_reject(32'h0, 4097);
        run_load(32'h0, 0, 0, 0);
        words_q = '{32'h0000_0013, 32'h0010_0093};
        run_load(32'h0, 2, 1, 0);
        run_reset_midload();
        for (int t = 0; t < 8; t++) begin
            run_load($urandom & 32'hFFFF_FFFC, $urandom_range(1, 6),
                     $urandom_range(0, 2), $urandom_range(0, 2));
        end
        run_load(32'h0, 4096, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
